// File: rtl/store_ctrl.sv
// store_ctrl
//   Store controller between the core's store path and the data-memory write
//   port. It takes one store at a time and decodes funct3 into a byte-enable
//   mask. Mask and data are shifted to the byte offset of the address, and the
//   store is issued as one or two word beats over a req/ack handshake.
//   Completion or error is reported back to the core as a one-cycle pulse.
//
//   Build option: define MISALIGNED_SPLIT_EN to execute stores that cross a
//   word boundary as two beats. Without it, such stores are rejected with
//   err_code 10 and never touch memory.
//
// Parameters
//   ADDR_W       address width in bits
//   ACK_TIMEOUT  cycles a beat may wait for mem_ack before giving up (>= 1)
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   st_valid/st_ready   core request handshake (accept = valid && ready)
//   funct3_ls           000 SB, 001 SH, 010 SW; anything else is illegal
//   addr_ls, wdata_ls   byte address and LSB-justified store data
//   mem_req/mem_ack     memory write handshake, one beat per ack
//   mem_addr            word-aligned beat address (0 while mem_req=0)
//   mem_wdata, mem_be   lane-aligned data and byte enables (0 while mem_req=0)
//   st_done, st_err     completion pulse, error flag coincident with it
//   err_code            00 ok, 01 illegal funct3, 10 misaligned, 11 timeout
module store_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        funct3_ls,
  input  logic [ADDR_W-1:0] addr_ls,
  input  logic [31:0]       wdata_ls,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err,
  output logic [1:0]        err_code
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
    BEAT1 = 2'd2,
`endif
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              timeout_hit;

  logic [3:0]        base_be;
  logic              illegal;
  logic [7:0]        mask8;
  logic              misaligned;
  logic [31:0]       data_lo;
  logic [ADDR_W-1:0] addr0;

`ifdef MISALIGNED_SPLIT_EN
  logic [63:0]       data64;
  logic [ADDR_W-1:0] addr1;
  logic              split;
  logic [ADDR_W-1:0] hi_addr;
  logic [31:0]       hi_wdata;
  logic [3:0]        hi_be;
`endif

  // Decode the incoming request straight off the core's inputs so that the
  // accept cycle can already pick between error response and first beat.
  // The upper nibble of the 8-bit mask is whatever spills into the next word.
  always_comb begin
    base_be = 4'b0000;
    illegal = 1'b0;
    case (funct3_ls)
      3'b000:  base_be = 4'b0001;
      3'b001:  base_be = 4'b0011;
      3'b010:  base_be = 4'b1111;
      default: illegal = 1'b1;
    endcase
    mask8      = {4'b0000, base_be} << addr_ls[1:0];
    misaligned = |mask8[7:4];
    addr0      = {addr_ls[ADDR_W-1:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
    data64     = {32'h0000_0000, wdata_ls} << {addr_ls[1:0], 3'b000};
    data_lo    = data64[31:0];
    addr1      = addr0 + ADDR_W'(4);
`else
    data_lo    = wdata_ls << {addr_ls[1:0], 3'b000};
`endif
  end

  // Wait counter for the current beat; the beat gives up on the edge where
  // the count would reach ACK_TIMEOUT, so mem_req is up for exactly that many
  // cycles when no ack ever arrives.
  assign cnt_next    = cnt + CNT_W'(1);
  assign timeout_hit = (cnt_next == CNT_LIMIT);

  // Control FSM with every output registered. The memory-side outputs are
  // zeroed whenever a beat ends so they read 0 whenever mem_req is low, and
  // the done/err pulse defaults low each cycle so it lasts only the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      st_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      err_code  <= 2'b00;
      cnt       <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split     <= 1'b0;
      hi_addr   <= '0;
      hi_wdata  <= '0;
      hi_be     <= '0;
`endif
    end else begin
      st_done  <= 1'b0;
      st_err   <= 1'b0;
      err_code <= 2'b00;
      case (state)
        IDLE: begin
          if (st_valid) begin
            st_ready <= 1'b0;
            if (illegal) begin
              state    <= RESP;
              st_done  <= 1'b1;
              st_err   <= 1'b1;
              err_code <= 2'b01;
            end
`ifndef MISALIGNED_SPLIT_EN
            else if (misaligned) begin
              state    <= RESP;
              st_done  <= 1'b1;
              st_err   <= 1'b1;
              err_code <= 2'b10;
            end
`endif
            else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= addr0;
              mem_wdata <= data_lo;
              mem_be    <= mask8[3:0];
              cnt       <= '0;
`ifdef MISALIGNED_SPLIT_EN
              split     <= misaligned;
              hi_addr   <= addr1;
              hi_wdata  <= data64[63:32];
              hi_be     <= mask8[7:4];
`endif
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
            if (split) begin
              state     <= BEAT1;
              mem_addr  <= hi_addr;
              mem_wdata <= hi_wdata;
              mem_be    <= hi_be;
              cnt       <= '0;
            end else
`endif
            begin
              state     <= RESP;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= '0;
              st_done   <= 1'b1;
            end
          end else if (timeout_hit) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            st_done   <= 1'b1;
            st_err    <= 1'b1;
            err_code  <= 2'b11;
          end else begin
            cnt <= cnt_next;
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        // A timeout here leaves beat 0 already in memory; only err 11 says so.
        BEAT1: begin
          if (mem_ack || timeout_hit) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            st_done   <= 1'b1;
            st_err    <= !mem_ack;
            err_code  <= mem_ack ? 2'b00 : 2'b11;
          end else begin
            cnt <= cnt_next;
          end
        end
`endif
        RESP: begin
          state    <= IDLE;
          st_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          st_ready  <= 1'b1;
          mem_req   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_be    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_ctrl.sv
// tb_store_ctrl
//   Self-checking bench for store_ctrl. A behavioural model derives the
//   expected beats from the store size and byte offset with plain arithmetic.
//   Directed steps cover the reset state, the single-beat, split and error
//   paths, the ack timeout, reset during a beat and address wrap. A randomized
//   loop of stores then runs with random ack latencies.
//   Works in either build: the model follows MISALIGNED_SPLIT_EN as well.
module tb_store_ctrl;

  localparam int ADDR_W = 32;
  localparam int TO     = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [2:0]        funct3_ls;
  logic [ADDR_W-1:0] addr_ls;
  logic [31:0]       wdata_ls;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              st_done;
  logic              st_err;
  logic [1:0]        err_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  store_ctrl #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .funct3_ls (funct3_ls),
    .addr_ls   (addr_ls),
    .wdata_ls  (wdata_ls),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .st_done   (st_done),
    .st_err    (st_err),
    .err_code  (err_code)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // One comparison: count it, and on a difference count and report it
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven and
  // registered outputs are stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: store size and byte offset give the byte lanes touched.
  // The data is placed by multiplying by 256 per byte of offset. Lanes past 3
  // belong to the next word.
  task automatic model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output int nb, output logic [1:0] perr, output beat_t b0, output beat_t b1);
    int size;
    int off;
    longint unsigned d;
    longint unsigned m;
    perr = 2'b00;
    nb   = 0;
    case (f3)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      default: size = 0;
    endcase
    off = int'(addr % 4);
    d = longint'(wd);
    for (int i = 0; i < off; i++) d = d * 256;
    m = longint'((2 ** size) - 1) * longint'(2 ** off);
    b0.a  = addr - 32'(off);
    b0.be = 4'(m % 16);
    b0.d  = 32'(d % 64'h1_0000_0000);
    b1.a  = b0.a + 32'd4;
    b1.be = 4'(m / 16);
    b1.d  = 32'(d / 64'h1_0000_0000);
    if (size == 0) begin
      perr = 2'b01;
    end else if (off + size > 4) begin
`ifdef MISALIGNED_SPLIT_EN
      nb = 2;
`else
      perr = 2'b10;
`endif
    end else begin
      nb = 1;
    end
  endtask

  // Issue one store and follow it to completion. d0/d1 are the wait cycles
  // before mem_ack in each beat; a negative value means never acknowledge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                               input int d0, input int d1);
    beat_t      bt[2];
    int         nb;
    int         dl[2];
    logic [1:0] e;
    bit         timed_out;
    timed_out = 1'b0;
    model(f3, addr, wd, nb, e, bt[0], bt[1]);
    dl[0] = d0;
    dl[1] = d1;
    checkOutput("idle_ready", {63'd0, st_ready}, 64'd1);
    st_valid  = 1'b1;
    funct3_ls = f3;
    addr_ls   = addr;
    wdata_ls  = wd;
    tick();
    st_valid  = 1'b0;
    funct3_ls = 3'($urandom);
    addr_ls   = $urandom;
    wdata_ls  = $urandom;
    for (int j = 0; j < nb && !timed_out; j++) begin
      for (int c = 0; c < TO; c++) begin
        checkOutput("beat_req",   {63'd0, mem_req},  64'd1);
        checkOutput("beat_addr",  {32'd0, mem_addr}, {32'd0, bt[j].a});
        checkOutput("beat_wdata", {32'd0, mem_wdata}, {32'd0, bt[j].d});
        checkOutput("beat_be",    {60'd0, mem_be},   {60'd0, bt[j].be});
        checkOutput("beat_done",  {63'd0, st_done},  64'd0);
        checkOutput("beat_ready", {63'd0, st_ready}, 64'd0);
        if (c == dl[j]) begin
          mem_ack = 1'b1;
          tick();
          mem_ack = 1'b0;
          break;
        end
        tick();
        if (c == TO - 1) timed_out = 1'b1;
      end
    end
    if (timed_out) e = 2'b11;
    // Response cycle; a stray ack here must be ignored
    mem_ack = 1'($urandom_range(0, 1));
    checkOutput("resp_done",  {63'd0, st_done},  64'd1);
    checkOutput("resp_err",   {63'd0, st_err},   {63'd0, (e != 2'b00)});
    checkOutput("resp_code",  {62'd0, err_code}, {62'd0, e});
    checkOutput("resp_req",   {63'd0, mem_req},  64'd0);
    checkOutput("resp_addr",  {32'd0, mem_addr}, 64'd0);
    checkOutput("resp_wdata", {32'd0, mem_wdata}, 64'd0);
    checkOutput("resp_be",    {60'd0, mem_be},   64'd0);
    checkOutput("resp_ready", {63'd0, st_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    checkOutput("post_done",  {63'd0, st_done},  64'd0);
    checkOutput("post_code",  {62'd0, err_code}, 64'd0);
    checkOutput("post_ready", {63'd0, st_ready}, 64'd1);
    checkOutput("post_req",   {63'd0, mem_req},  64'd0);
  endtask

  initial begin : main
    int          r;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          d0;
    int          d1;

    rst       = 1'b1;
    st_valid  = 1'b0;
    funct3_ls = 3'd0;
    addr_ls   = '0;
    wdata_ls  = '0;
    mem_ack   = 1'b0;
    $display("[TB] start");

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", {63'd0, st_ready}, 64'd1);
    checkOutput("rst_req",   {63'd0, mem_req},  64'd0);
    checkOutput("rst_done",  {63'd0, st_done},  64'd0);
    checkOutput("rst_err",   {63'd0, st_err},   64'd0);
    checkOutput("rst_addr",  {32'd0, mem_addr}, 64'd0);
    checkOutput("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    checkOutput("rst_be",    {60'd0, mem_be},   64'd0);
    checkOutput("rst_code",  {62'd0, err_code}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed cases
    applyStimulus(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 0);
    applyStimulus(3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 0);
    applyStimulus(3'b001, 32'h0000_0203, 32'h0000_1234, 1, 0);
    applyStimulus(3'b011, 32'h0000_0300, 32'h1111_2222, 0, 0);
    applyStimulus(3'b010, 32'h0000_0400, 32'hCAFE_F00D, -1, 0);
    applyStimulus(3'b010, 32'h0000_0500, 32'h0BAD_F00D, TO - 1, 0);
    applyStimulus(3'b010, 32'hFFFF_FFFE, 32'hA5A5_5A5A, 0, 1);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_BEEF, 0, -1);
    applyStimulus(3'b000, 32'h0000_0602, 32'hFFFF_FF77, 3, 0);

    // Reset during the first beat aborts without a done pulse
    checkOutput("abort_idle", {63'd0, st_ready}, 64'd1);
    st_valid  = 1'b1;
    funct3_ls = 3'b010;
    addr_ls   = 32'h0000_0700;
    wdata_ls  = 32'h1234_5678;
    tick();
    st_valid = 1'b0;
    checkOutput("abort_req_before", {63'd0, mem_req}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_req",   {63'd0, mem_req},  64'd0);
    checkOutput("abort_be",    {60'd0, mem_be},   64'd0);
    checkOutput("abort_ready", {63'd0, st_ready}, 64'd1);
    checkOutput("abort_done",  {63'd0, st_done},  64'd0);
    repeat (3) begin
      tick();
      checkOutput("abort_hold_done", {63'd0, st_done}, 64'd0);
      checkOutput("abort_hold_req",  {63'd0, mem_req}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("abort_after_ready", {63'd0, st_ready}, 64'd1);
    applyStimulus(3'b010, 32'h0000_0800, 32'h8765_4321, 1, 0);

    // Randomized stores with random ack latency
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      f3 = 3'b000;
      else if (r < 6) f3 = 3'b001;
      else if (r < 9) f3 = 3'b010;
      else            f3 = 3'($urandom_range(3, 7));
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      d0 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      d1 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      applyStimulus(f3, addr, $urandom, d0, d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
